// File: rtl/channel_scan_pkg.sv
// Shared types and helpers for the channel scan sequencer that drives the
// 2-to-4 decoder select lines.
package channel_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Index of the lowest enabled channel; 0 when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/channel_scan_ctrl_if.sv
// Control/status bundle between a scan requester and channel_scan_ctrl.
interface channel_scan_ctrl_if;
  import channel_scan_pkg::*;

  logic              start;
  logic              stop;
  logic              continuous;
  logic [NUM_CH-1:0] en_mask;
  logic [SEL_W-1:0]  sel;
  logic              sel_valid;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, stop, continuous, en_mask,
    input  sel, sel_valid, busy, frame_done
  );

  modport slave (
    input  start, stop, continuous, en_mask,
    output sel, sel_valid, busy, frame_done
  );

endinterface

// File: rtl/next_enabled_ch.sv
// Finds the next higher enabled channel above the current select; found=0
// means the current channel is the last one of the frame.
module next_enabled_ch
  import channel_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next,
  output logic              found
);

  always_comb begin
    next  = cur;
    found = 1'b0;
    // Descending walk so the lowest qualifying index is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        next  = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_scan_ctrl.sv
// Steps the decoder select through the latched channel mask, holding each
// enabled channel for DWELL_CYCLES cycles, one-shot or continuous.
module channel_scan_ctrl
  import channel_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = $clog2(DWELL_CYCLES + 1)
) (
  input logic                clk,
  input logic                rst,
  channel_scan_ctrl_if.slave bus
);

  scan_state_t       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              frame_done_q, frame_done_d;

  logic [SEL_W-1:0]  next_ch;
  logic              next_found;
  logic              dwell_end;

  next_enabled_ch u_next (
    .mask  (mask_q),
    .cur   (sel_q),
    .next  (next_ch),
    .found (next_found)
  );

  assign dwell_end = (cnt == CNT_W'(DWELL_CYCLES - 1));

  // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    mask_d       = mask_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.en_mask != '0)) begin
          state_d = SCAN;
          mask_d  = bus.en_mask;
          sel_d   = lowest_set(bus.en_mask);
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (dwell_end) begin
          cnt_d = '0;
          if (next_found) begin
            sel_d = next_ch;
          end else begin
            frame_done_d = 1'b1;
            if (bus.continuous && (bus.en_mask != '0)) begin
              mask_d = bus.en_mask;
              sel_d  = lowest_set(bus.en_mask);
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mask_q       <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      mask_q       <= mask_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_valid  = (state == SCAN);
  assign bus.busy       = (state == SCAN);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_channel_scan_ctrl.sv
// Self-checking bench: table-driven cycle vectors on a DWELL_CYCLES=4 instance
// plus hand sequences for async reset and a DWELL_CYCLES=1 instance.
module tb_channel_scan_ctrl;

  typedef struct packed {
    logic [1:0] sel;
    logic       valid;
    logic       busy;
    logic       fd;
  } out_t;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] mask;
    int         reps;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  vec_t vecs[$];
  out_t exp_q[$];

  channel_scan_ctrl_if if4 ();
  channel_scan_ctrl_if if1 ();

  channel_scan_ctrl #(.DWELL_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  channel_scan_ctrl #(.DWELL_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  function automatic out_t o(input logic [1:0] s, input logic v, input logic fd);
    out_t r;
    r.sel   = s;
    r.valid = v;
    r.busy  = v;
    r.fd    = fd;
    return r;
  endfunction

  function automatic out_t get4();
    out_t r;
    r.sel = if4.sel; r.valid = if4.sel_valid; r.busy = if4.busy; r.fd = if4.frame_done;
    return r;
  endfunction

  function automatic out_t get1();
    out_t r;
    r.sel = if1.sel; r.valid = if1.sel_valid; r.busy = if1.busy; r.fd = if1.frame_done;
    return r;
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got sel=%0d valid=%b busy=%b fd=%b, want sel=%0d valid=%b busy=%b fd=%b",
               nm, act.sel, act.valid, act.busy, act.fd, exp.sel, exp.valid, exp.busy, exp.fd);
    end
  endtask

  function automatic void add(input string nm, input logic st, input logic sp, input logic ct,
                              input logic [3:0] m, input int reps, input out_t e);
    vec_t v;
    v.name = nm; v.start = st; v.stop = sp; v.cont = ct; v.mask = m; v.reps = reps; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Drive one cycle on the selected instance, push the expectation, then
  // compare after the edge.
  task automatic cycle(input bit use1, input logic st, input logic sp, input logic ct,
                       input logic [3:0] m, input out_t e, input string nm);
    out_t act;
    if (use1) begin
      if1.start = st; if1.stop = sp; if1.continuous = ct; if1.en_mask = m;
    end else begin
      if4.start = st; if4.stop = sp; if4.continuous = ct; if4.en_mask = m;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    act = use1 ? get1() : get4();
    check(nm, act, exp_q.pop_front());
  endtask

  initial begin
    if4.start = 0; if4.stop = 0; if4.continuous = 0; if4.en_mask = '0;
    if1.start = 0; if1.stop = 0; if1.continuous = 0; if1.en_mask = '0;

    // One-shot, full mask: 4 cycles per channel, frame_done 16 cycles after start.
    add("full_start", 1, 0, 0, 4'b1111, 1, o(0, 1, 0));
    add("full_ch0",   0, 0, 0, 4'b1111, 3, o(0, 1, 0));
    add("full_ch1",   0, 0, 0, 4'b1111, 4, o(1, 1, 0));
    add("full_ch2",   0, 0, 0, 4'b1111, 4, o(2, 1, 0));
    add("full_ch3",   0, 0, 0, 4'b1111, 4, o(3, 1, 0));
    add("full_done",  0, 0, 0, 4'b1111, 1, o(3, 0, 1));
    add("full_idle",  0, 0, 0, 4'b1111, 1, o(3, 0, 0));
    // Sparse mask 1010.
    add("sparse_start", 1, 0, 0, 4'b1010, 1, o(1, 1, 0));
    add("sparse_ch1",   0, 0, 0, 4'b1010, 3, o(1, 1, 0));
    add("sparse_ch3",   0, 0, 0, 4'b1010, 4, o(3, 1, 0));
    add("sparse_done",  0, 0, 0, 4'b1010, 1, o(3, 0, 1));
    // Continuous 1001, mask switched to 0100 mid-frame.
    add("cont_start",  1, 0, 1, 4'b1001, 1, o(0, 1, 0));
    add("cont_ch0",    0, 0, 1, 4'b0100, 3, o(0, 1, 0));
    add("cont_ch3",    0, 0, 1, 4'b0100, 4, o(3, 1, 0));
    add("cont_f2_fd",  0, 0, 1, 4'b0100, 1, o(2, 1, 1));
    add("cont_f2",     0, 0, 1, 4'b0100, 3, o(2, 1, 0));
    add("cont_f3_fd",  0, 0, 1, 4'b0100, 1, o(2, 1, 1));
    add("cont_f3",     0, 0, 1, 4'b0100, 3, o(2, 1, 0));
    add("cont_stop",   0, 1, 1, 4'b0100, 1, o(2, 0, 0));
    // Stop mid-dwell of channel 2, then a start with an empty mask.
    add("stop_start",  1, 0, 0, 4'b1111, 1, o(0, 1, 0));
    add("stop_ch0",    0, 0, 0, 4'b1111, 3, o(0, 1, 0));
    add("stop_ch1",    0, 0, 0, 4'b1111, 4, o(1, 1, 0));
    add("stop_ch2",    0, 0, 0, 4'b1111, 1, o(2, 1, 0));
    add("stop_hit",    0, 1, 0, 4'b1111, 1, o(2, 0, 0));
    add("stop_idle",   0, 0, 0, 4'b1111, 2, o(2, 0, 0));
    add("empty_start", 1, 0, 0, 4'b0000, 1, o(2, 0, 0));
    add("empty_idle",  0, 0, 0, 4'b0000, 1, o(2, 0, 0));
    // start+stop collision, then start ignored while busy.
    add("collide",     1, 1, 0, 4'b1111, 1, o(2, 0, 0));
    add("re_start",    1, 0, 0, 4'b0011, 1, o(0, 1, 0));
    add("busy_start",  1, 0, 0, 4'b1111, 1, o(0, 1, 0));
    add("re_ch0",      0, 0, 0, 4'b1111, 2, o(0, 1, 0));
    add("re_ch1",      0, 0, 0, 4'b1111, 4, o(1, 1, 0));
    add("re_done",     0, 0, 0, 4'b1111, 1, o(1, 0, 1));
    add("re_idle",     0, 0, 0, 4'b1111, 1, o(1, 0, 0));

    // Reset asserted away from any clock edge.
    #2 rst = 1'b1;
    #2;
    check("reset_state", get4(), o(0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        cycle(0, vecs[i].start, vecs[i].stop, vecs[i].cont, vecs[i].mask, vecs[i].exp,
              $sformatf("%s[%0d]", vecs[i].name, k));
      end
    end

    // Async reset mid-frame: outputs clear before the next edge.
    cycle(0, 1, 0, 0, 4'b1111, o(0, 1, 0), "rst_pre_start");
    cycle(0, 0, 0, 0, 4'b1111, o(0, 1, 0), "rst_pre_ch0");
    cycle(1, 1, 0, 0, 4'b1110, o(1, 1, 0), "rst_pre_d1");
    #3 rst = 1'b1;
    #1;
    check("rst_mid_d4", get4(), o(0, 0, 0));
    check("rst_mid_d1", get1(), o(0, 0, 0));
    if1.start = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(0, 0, 0, 0, 4'b1111, o(0, 0, 0), "rst_wait_d4");
    cycle(1, 0, 0, 0, 4'b1111, o(0, 0, 0), "rst_wait_d1");

    // DWELL_CYCLES=1, single channel continuous: frame_done every cycle.
    cycle(1, 1, 0, 1, 4'b0001, o(0, 1, 0), "d1_start");
    for (int k = 0; k < 4; k++)
      cycle(1, 0, 0, 1, 4'b0001, o(0, 1, 1), $sformatf("d1_cont[%0d]", k));
    cycle(1, 0, 0, 0, 4'b1111, o(0, 0, 1), "d1_last");
    // DWELL_CYCLES=1 full mask: channel changes every cycle.
    cycle(1, 1, 0, 0, 4'b1111, o(0, 1, 0), "d1_full0");
    for (int k = 1; k < 4; k++)
      cycle(1, 0, 0, 0, 4'b1111, o(2'(k), 1, 0), $sformatf("d1_full%0d", k));
    cycle(1, 0, 0, 0, 4'b1111, o(3, 0, 1), "d1_full_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
